// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the 0x8000_xxxx I/O window: register offsets, SSel size codes
// and the window nibble used by the controller, the load unit and the responder.
package mmio_responder_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2,
      SIZE_NONE = 2'd3
   } mem_size_e;

   localparam logic [3:0] MEM_WINDOW = 4'h8;

   localparam logic [7:0] UART_CTRL = 8'h00;
   localparam logic [7:0] UART_RX   = 8'h04;
   localparam logic [7:0] UART_TX   = 8'h08;
   localparam logic [7:0] CYCLE_CNT = 8'h10;
   localparam logic [7:0] INSTR_CNT = 8'h14;
   localparam logic [7:0] CNT_RST   = 8'h18;

   typedef struct packed {
      logic rx_ovf;
      logic tx_ovf;
      logic rx_nonempty;
      logic tx_notfull;
   } uart_status_t;

   function automatic logic in_window(input logic [31:0] addr, input logic [3:0] window);
      return addr[31:28] == window;
   endfunction

endpackage

// File: rtl/mmio_responder_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder for UART FIFOs and the cycle / retired-instruction counters;
// load data is registered and presented the cycle after the request.
module mmio_responder
   import mmio_responder_pkg::*;
#(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = {MEM_WINDOW, 28'h0}
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   input  logic        inst_retire,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   logic        hit;
   logic        wr;
   logic        rd;
   logic [7:0]  off;
   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        tx_empty;
   logic        tx_drop;
   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic        rx_drop;
   logic [7:0]  rx_head;
   logic        tx_ovf;
   logic        rx_ovf;
   logic        flag_clear;
   logic        cnt_clear;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
   logic [31:0] read_val;
   uart_status_t status;
   logic        unused_bits;

   assign unused_bits = &{1'b0, req_addr[27:8], req_addr[1:0], req_wdata[31:8]};

   assign hit = req_valid && in_window(req_addr, BASE_ADDR[31:28]);
   assign wr  = hit && req_we && (req_size != SIZE_NONE);
   assign rd  = hit && !req_we;
   assign off = {req_addr[7:2], 2'b00};

   assign flag_clear = wr && (off == UART_CTRL);
   assign cnt_clear  = wr && (off == CNT_RST);

   assign tx_push  = wr && (off == UART_TX);
   assign tx_valid = !tx_empty;
   assign tx_pop   = tx_valid && tx_ready;
   assign tx_drop  = tx_push && tx_full && !tx_pop;

   // A core pop frees a slot this very cycle, so a full RX FIFO can still take a byte.
   assign rx_pop   = rd && (off == UART_RX) && !rx_empty;
   assign rx_ready = !rx_full || rx_pop;
   assign rx_push  = rx_valid && rx_ready;
   assign rx_drop  = rx_valid && !rx_ready;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_push),
      .push_data (req_wdata[7:0]),
      .pop       (tx_pop),
      .head      (tx_data),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_push),
      .push_data (rx_data),
      .pop       (rx_pop),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // A fresh overflow in the same cycle as a clearing write is kept, so no loss goes unseen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_ovf <= 1'b0;
         rx_ovf <= 1'b0;
      end else begin
         if (flag_clear) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
         end
         if (tx_drop) tx_ovf <= 1'b1;
         if (rx_drop) rx_ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else if (cnt_clear) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         if (inst_retire) instr_cnt <= instr_cnt + 32'd1;
      end
   end

   always_comb begin
      status.rx_ovf      = rx_ovf;
      status.tx_ovf      = tx_ovf;
      status.rx_nonempty = !rx_empty;
      status.tx_notfull  = !tx_full;
      read_val = '0;
      case (off)
         UART_CTRL: read_val = {28'd0, status};
         UART_RX:   read_val = rx_empty ? 32'd0 : {24'd0, rx_head};
         CYCLE_CNT: read_val = cycle_cnt;
         INSTR_CNT: read_val = instr_cnt;
         default:   read_val = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (rd) rdata <= read_val;
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a queue-based reference model predicts load data and the TX
// byte stream, and separate monitors compare them as the DUT presents them.
module tb_mmio_responder;
   import mmio_responder_pkg::*;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_we;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        inst_retire;
   logic [31:0] rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  tx_sb[$];
   logic [31:0] rd_sb[$];
   logic [31:0] m_cyc;
   logic [31:0] m_instr;
   logic [31:0] m_last;
   logic        m_tx_ovf;
   logic        m_rx_ovf;
   logic        rd_pend = 1'b0;

   always #5 clk = ~clk;

   mmio_responder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(32'h8000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_addr    (req_addr),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_wdata   (req_wdata),
      .inst_retire (inst_retire),
      .rdata       (rdata),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] win_addr(input logic [7:0] off);
      return {4'h8, 20'($urandom), off[7:2], 2'($urandom)};
   endfunction

   function automatic void model_clear();
      tx_q.delete();
      rx_q.delete();
      tx_sb.delete();
      rd_sb.delete();
      m_cyc    = '0;
      m_instr  = '0;
      m_last   = '0;
      m_tx_ovf = 1'b0;
      m_rx_ovf = 1'b0;
   endfunction

   // Load data monitor: the value for a request shows up after the following clock edge.
   // TX monitor: every byte handed over must be the next one the model accepted.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            rd_pend = 1'b0;
         end else begin
            if (rd_pend) begin
               if (rd_sb.size() == 0) check_output("rd_scoreboard_empty", rdata, 32'hDEAD_BEEF);
               else check_output("rdata", rdata, rd_sb.pop_front());
            end
            if (tx_valid && tx_ready) begin
               if (tx_sb.size() == 0) check_output("tx_unexpected_byte", {24'd0, tx_data}, 32'hDEAD_BEEF);
               else check_output("tx_data", {24'd0, tx_data}, {24'd0, tx_sb.pop_front()});
            end
            rd_pend = req_valid && !req_we;
         end
      end
   end

   // One clock of stimulus, entered and left at posedge+1; the model advances by one edge.
   task automatic apply_stimulus(input logic v, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic [31:0] wdata,
                                 input logic retire, input logic rxv, input logic [7:0] rxd,
                                 input logic txr);
      logic       hit, wr, rd, tx_pop, rx_pop, exp_rx_ready;
      logic [7:0] off;
      logic [31:0] exp;
      req_valid = v; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
      inst_retire = retire; rx_valid = rxv; rx_data = rxd; tx_ready = txr;

      hit = v && (addr[31:28] == 4'h8);
      wr  = hit && we && (size != 2'd3);
      rd  = hit && !we;
      off = {addr[7:2], 2'b00};
      tx_pop = txr && (tx_q.size() != 0);
      rx_pop = rd && (off == 8'h04) && (rx_q.size() != 0);
      exp_rx_ready = (rx_q.size() < DEPTH) || rx_pop;

      if (v && !we) begin
         exp = m_last;
         if (rd) begin
            case (off)
               8'h00: exp = {28'd0, m_rx_ovf, m_tx_ovf, rx_q.size() != 0, tx_q.size() < DEPTH};
               8'h04: exp = (rx_q.size() != 0) ? {24'd0, rx_q[0]} : 32'd0;
               8'h10: exp = m_cyc;
               8'h14: exp = m_instr;
               default: exp = 32'd0;
            endcase
         end
         rd_sb.push_back(exp);
         m_last = exp;
      end

      @(negedge clk);
      check_output("rx_ready", {31'd0, rx_ready}, {31'd0, exp_rx_ready});
      check_output("tx_valid", {31'd0, tx_valid}, {31'd0, tx_q.size() != 0});

      if (wr && off == 8'h00) begin
         m_tx_ovf = 1'b0;
         m_rx_ovf = 1'b0;
      end
      if (wr && off == 8'h08) begin
         if (tx_q.size() < DEPTH || tx_pop) begin
            tx_q.push_back(wdata[7:0]);
            tx_sb.push_back(wdata[7:0]);
         end else begin
            m_tx_ovf = 1'b1;
         end
      end
      if (tx_pop) void'(tx_q.pop_front());
      if (rx_pop) void'(rx_q.pop_front());
      if (rxv) begin
         if (exp_rx_ready) rx_q.push_back(rxd);
         else m_rx_ovf = 1'b1;
      end
      if (wr && off == 8'h18) begin
         m_cyc = '0;
         m_instr = '0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         if (retire) m_instr = m_instr + 32'd1;
      end

      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic txr);
      apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b0, 8'd0, txr);
   endtask

   task automatic read_reg(input logic [31:0] addr, input logic txr);
      apply_stimulus(1'b1, 1'b0, addr, 2'd2, 32'($urandom), 1'b0, 1'b0, 8'd0, txr);
   endtask

   task automatic write_reg(input logic [31:0] addr, input logic [31:0] wdata, input logic txr);
      apply_stimulus(1'b1, 1'b1, addr, 2'($urandom_range(0, 2)), wdata, 1'b0, 1'b0, 8'd0, txr);
   endtask

   task automatic do_reset();
      req_valid = 1'b0; req_we = 1'b0; rx_valid = 1'b0; inst_retire = 1'b0; tx_ready = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #2;
      check_output("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
      check_output("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
      check_output("reset_rdata", rdata, 32'd0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_size = 2'd2; req_wdata = '0;
      inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_output("init_tx_valid", {31'd0, tx_valid}, 32'd0);
      check_output("init_rx_ready", {31'd0, rx_ready}, 32'd1);
      check_output("init_rdata", rdata, 32'd0);
      rst = 1'b0;

      // TX fill beyond depth with the transmitter stalled, then drain
      for (int i = 0; i < 9; i++) write_reg(win_addr(UART_TX), 32'h41 + 32'(i), 1'b0);
      read_reg(win_addr(UART_CTRL), 1'b0);
      for (int i = 0; i < 12; i++) idle_cycle(1'b1);
      write_reg(win_addr(UART_CTRL), 32'd0, 1'b1);
      read_reg(win_addr(UART_CTRL), 1'b1);

      // RX path, including a read from the empty FIFO
      apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b1, 8'h55, 1'b1);
      apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b1, 8'hAA, 1'b1);
      read_reg(win_addr(UART_CTRL), 1'b1);
      for (int i = 0; i < 3; i++) read_reg(win_addr(UART_RX), 1'b1);

      // Counters: 5 retirements over 10 cycles, then a clear racing a retirement
      for (int i = 0; i < 10; i++)
         apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'(i % 2), 1'b0, 8'd0, 1'b1);
      read_reg(win_addr(INSTR_CNT), 1'b1);
      apply_stimulus(1'b1, 1'b1, win_addr(CNT_RST), 2'd2, 32'd0, 1'b1, 1'b0, 8'd0, 1'b1);
      read_reg(win_addr(INSTR_CNT), 1'b1);
      read_reg(win_addr(CYCLE_CNT), 1'b1);

      // Unmapped offset, then an out-of-window load that must leave rdata alone
      read_reg(win_addr(CYCLE_CNT), 1'b1);
      read_reg(32'h8000_0040, 1'b1);
      read_reg(win_addr(CYCLE_CNT), 1'b1);
      read_reg(32'h1000_0000, 1'b1);
      idle_cycle(1'b1);

      // RX full: simultaneous pop and push keeps the count, then a true overflow
      for (int i = 0; i < DEPTH; i++)
         apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b1, 8'h10 + 8'(i), 1'b1);
      apply_stimulus(1'b1, 1'b0, win_addr(UART_RX), 2'd2, 32'd0, 1'b0, 1'b1, 8'h99, 1'b1);
      read_reg(win_addr(UART_CTRL), 1'b1);
      apply_stimulus(1'b0, 1'b0, 32'd0, 2'd2, 32'd0, 1'b0, 1'b1, 8'hEE, 1'b1);
      read_reg(win_addr(UART_CTRL), 1'b1);
      for (int i = 0; i < DEPTH + 1; i++) read_reg(win_addr(UART_RX), 1'b1);

      // Reset in the middle of TX traffic
      for (int i = 0; i < 3; i++) write_reg(win_addr(UART_TX), 32'h60 + 32'(i), 1'b0);
      do_reset();
      for (int i = 0; i < 3; i++) idle_cycle(1'b0);
      read_reg(win_addr(CYCLE_CNT), 1'b0);

      // Randomized traffic across the whole register map
      for (int n = 0; n < 400; n++) begin
         logic [7:0]  offs [8];
         logic [31:0] addr;
         offs = '{UART_CTRL, UART_RX, UART_TX, 8'h0C, CYCLE_CNT, INSTR_CNT, CNT_RST, 8'h40};
         addr = ($urandom_range(0, 9) == 0) ? (32'h1000_0000 | 32'($urandom_range(0, 255)))
                                            : win_addr(offs[$urandom_range(0, 7)]);
         apply_stimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 2) == 0), addr,
                        2'($urandom), 32'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                        8'($urandom), 1'($urandom_range(0, 3) != 0));
      end

      for (int i = 0; i < 2 * DEPTH; i++) idle_cycle(1'b1);
      check_output("rd_scoreboard_drained", 32'(rd_sb.size()), 32'd0);
      check_output("tx_scoreboard_drained", 32'(tx_sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
